boron_xor_encrypt_stage: RTL and testbench
==========================================

Name: boron_xor_encrypt_stage

Overview:
Registered, valid/ready-handshaked BORON encryption XOR layer. It is the forward counterpart of the decryption XOR layer: boron_xor_encrypt_stage followed by the decryption XOR gives the identity on every 64-bit block. It sits in the encryption round pipeline and sustains full throughput under downstream back-pressure using a 2-entry skid buffer. It also provides a per-beat bypass and a delivered-block counter.

Parameters:
CNT_W, 32, width of the delivered-block counter blk_cnt_o.

Ports:
clk_i  in  1  single clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
in_valid_i  in  1  input beat valid.
in_ready_o  out  1  stage can accept an input beat.
data_i  in  64  plaintext-side block; lanes x1=[15:0], x2=[31:16], x3=[47:32], x4=[63:48].
bypass_i  in  1  sampled with the beat; 1 passes data_i through unchanged.
out_valid_o  out  1  output beat valid.
out_ready_i  in  1  downstream accepts the output beat.
data_o  out  64  transformed block; lanes y1..y4 use the same bit positions as x1..x4.
blk_cnt_o  out  CNT_W  number of output beats delivered, counting bypassed beats.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid_o=0, data_o=0, in_ready_o=1, skid empty, blk_cnt_o=0.
- Transform, combinational on the input side, evaluated before registering:
  - y3 = x1^x3
  - y4 = x1^x3^x4
  - y2 = x2^x4
  - y1 = x1^x2^x4
  - bypass_i=1 gives y=x.
- Handshakes:
  - Input accepted when in_valid_i & in_ready_o.
  - Output delivered when out_valid_o & out_ready_i.
  - data_o and out_valid_o stay stable while out_valid_o=1 and out_ready_i=0.
- Latency: an accepted beat appears on data_o in the next cycle when the output register is empty or being drained.
- Throughput: 1 beat/cycle while out_ready_i=1.
- in_ready_o is a registered signal, equal to !skid_valid. It has no combinational path from out_ready_i.
- Storage:
  - Output register (main) plus one skid register.
  - An accept while main is full and not draining writes the transformed beat to skid; in_ready_o drops the next cycle.
  - On drain, skid moves to main and in_ready_o rises the next cycle.
- Simultaneous accept and drain with skid empty: the new beat loads main; out_valid_o stays 1.
- Simultaneous accept and drain with skid full: cannot occur, because in_ready_o=0.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.
- blk_cnt_o increments by 1 per delivered beat and wraps modulo 2^CNT_W (all-ones+1 gives 0).
- Reset mid-operation discards main and skid contents, clears the counter, and returns all outputs to their reset values immediately.
- in_valid_i=0: state holds; no spurious out_valid_o.

Decomposition:
- Shared package boron_pkg:
  - localparams BLK_W=64 and LANE_W=16.
  - Lane index constants.
  - A pure function boron_xor_enc(blk) for the transform above.
  - A matching boron_xor_dec(blk) for use by the verification model and the decryption side.
- One natural sub-module, boron_skid_buf (parameter W, 2-entry valid/ready register slice). Instantiate it with W=64 and place the transform in front of it. The counter stays in the top level.

Test Plan:
- Reset, then one beat data_i=0x0004_0003_0002_0001, bypass_i=0, out_ready_i=1 -> next cycle data_o=0x0006_0002_0006_0007, out_valid_o=1, blk_cnt_o=1 after delivery.
- Beat 0xFFFF_0000_0000_0000 -> data_o=0xFFFF_0000_FFFF_FFFF. The same beat with bypass_i=1 -> data_o=0xFFFF_0000_0000_0000.
- Back-pressure:
  - out_ready_i=0 while 3 beats are offered back-to-back: 2 are accepted, in_ready_o=0 from the cycle after the second accept, and data_o stays stable.
  - Then out_ready_i=1: the beats exit in order, in_ready_o returns to 1, and the third beat is accepted.
- Streaming round-trip: 1000 random beats with random in_valid_i and out_ready_i. Apply boron_xor_dec to each data_o beat; the result must equal the original data_i in order, and blk_cnt_o=1000.
- Counter wrap with CNT_W=4: deliver 17 beats -> blk_cnt_o=1.
- Assert rst_i mid-stream with both main and skid full -> out_valid_o=0, in_ready_o=1 and blk_cnt_o=0 in the same cycle. After release, a new beat is processed normally.

Source files
------------

// File: rtl/boron_pkg.sv
// -----------------------------------------------------------------------------
// boron_pkg
// Shared definitions for the BORON XOR layers.
//   BLK_W / LANE_W : block and lane widths.
//   LANE_X1..X4    : lane index of x1..x4 (and y1..y4) within a 64-bit block.
//   boron_xor_enc  : forward XOR layer.
//   boron_xor_dec  : inverse XOR layer. boron_xor_dec(boron_xor_enc(b)) == b.
// -----------------------------------------------------------------------------
package boron_pkg;

    localparam int BLK_W  = 64;
    localparam int LANE_W = 16;

    localparam int LANE_X1 = 0;
    localparam int LANE_X2 = 1;
    localparam int LANE_X3 = 2;
    localparam int LANE_X4 = 3;

    function automatic logic [BLK_W-1:0] boron_xor_enc(input logic [BLK_W-1:0] blk);
        logic [LANE_W-1:0] x1, x2, x3, x4;
        logic [LANE_W-1:0] y1, y2, y3, y4;
        x1 = blk[LANE_X1*LANE_W +: LANE_W];
        x2 = blk[LANE_X2*LANE_W +: LANE_W];
        x3 = blk[LANE_X3*LANE_W +: LANE_W];
        x4 = blk[LANE_X4*LANE_W +: LANE_W];
        y3 = x1 ^ x3;
        y4 = x1 ^ x3 ^ x4;
        y2 = x2 ^ x4;
        y1 = x1 ^ x2 ^ x4;
        return {y4, y3, y2, y1};
    endfunction

    // Undo the forward layer lane by lane:
    //   x4 = y3^y4, x2 = y2^x4, x1 = y1^y2, x3 = y3^x1.
    function automatic logic [BLK_W-1:0] boron_xor_dec(input logic [BLK_W-1:0] blk);
        logic [LANE_W-1:0] x1, x2, x3, x4;
        logic [LANE_W-1:0] y1, y2, y3, y4;
        y1 = blk[LANE_X1*LANE_W +: LANE_W];
        y2 = blk[LANE_X2*LANE_W +: LANE_W];
        y3 = blk[LANE_X3*LANE_W +: LANE_W];
        y4 = blk[LANE_X4*LANE_W +: LANE_W];
        x4 = y3 ^ y4;
        x2 = y2 ^ x4;
        x1 = y1 ^ y2;
        x3 = y3 ^ x1;
        return {x4, x3, x2, x1};
    endfunction

endpackage

// File: rtl/boron_skid_buf.sv
// -----------------------------------------------------------------------------
// boron_skid_buf
// Two-entry valid/ready register slice (main output register + skid register).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset.
//   in_valid, in_ready  : upstream handshake; in_data is the beat payload.
//   out_valid, out_ready: downstream handshake; out_data is the beat payload.
//   occupancy           : number of beats held (0..2), for observation.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both 1. A producer holding valid=1 keeps its payload stable
// until ready is seen; out_valid/out_data here obey that rule. in_ready is a
// register (= !skid_valid) with no combinational path from out_ready.
// -----------------------------------------------------------------------------
module boron_skid_buf
    import boron_pkg::*;
#(
    parameter int W = BLK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         drain;

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (drain) begin
            if (skid_valid) begin
                // in_ready is low while skid is full, so no accept here.
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end else begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end
        end
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: rtl/boron_xor_encrypt_stage.sv
// -----------------------------------------------------------------------------
// boron_xor_encrypt_stage
// Registered BORON encryption XOR layer with a 2-entry skid buffer.
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-high reset.
//   in_valid_i, in_ready_o    : input handshake.
//   data_i                    : plaintext-side block (x1=[15:0] .. x4=[63:48]).
//   bypass_i                  : per-beat; 1 passes data_i through unchanged.
//   out_valid_o, out_ready_i  : output handshake.
//   data_o                    : transformed block (y1..y4 in x1..x4 positions).
//   blk_cnt_o                 : delivered beats modulo 2^CNT_W.
// -----------------------------------------------------------------------------
module boron_xor_encrypt_stage
    import boron_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [63:0]      data_i,
    input  logic             bypass_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      data_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    logic [BLK_W-1:0] enc_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] blk_cnt;

    // Transform before registering so the stored beat is already final.
    assign enc_data = bypass_i ? data_i : boron_xor_enc(data_i);

    boron_skid_buf #(
        .W (BLK_W)
    ) u_skid (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (enc_data),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (data_o),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_cnt <= '0;
        end else if (out_valid_o && out_ready_i) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end

    assign blk_cnt_o = blk_cnt;

    // Occupancy is kept for debug probing only.
    logic unused_occ;
    assign unused_occ = ^occupancy;

endmodule

// File: tb/tb_boron_xor_encrypt_stage.sv
module tb_boron_xor_encrypt_stage;
  import boron_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        bypass = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] data_in = '0;

  logic        in_ready, out_valid;
  logic [63:0] data_out;
  logic [31:0] blk_cnt;
  logic        in_ready4, out_valid4;
  logic [63:0] data_out4;
  logic [3:0]  blk_cnt4;

  boron_xor_encrypt_stage #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data_in), .bypass_i(bypass), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .data_o(data_out), .blk_cnt_o(blk_cnt)
  );

  // Narrow-counter instance sharing every input, used for wrap checks.
  boron_xor_encrypt_stage #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .data_i(data_in), .bypass_i(bypass), .out_valid_o(out_valid4),
    .out_ready_i(out_ready), .data_o(data_out4), .blk_cnt_o(blk_cnt4)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] orig_q[$];
  bit          byp_q[$];
  int occ = 0;
  int delivered = 0;

  function automatic logic [63:0] ref_enc(input logic [63:0] x);
    logic [15:0] a, b, c, d;
    a = x[15:0]; b = x[31:16]; c = x[47:32]; d = x[63:48];
    return {a ^ c ^ d, a ^ c, b ^ d, a ^ b ^ d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); orig_q.delete(); byp_q.delete();
    occ = 0; delivered = 0;
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, predict the handshakes from the model, advance,
  // then compare every observable output against the model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic b, input logic r);
    bit acc, dlv;
    logic [63:0] o;
    bit ob;
    in_valid = v; data_in = d; bypass = b; out_ready = r;
    acc = v && (occ < 2);
    dlv = (occ > 0) && r;
    if (dlv) begin
      o  = orig_q.pop_front();
      ob = byp_q.pop_front();
      if (ob) check("bypass_out", data_out, o);
      else    check("roundtrip", boron_xor_dec(data_out), o);
    end
    @(posedge clk); #1;
    if (dlv) begin
      void'(exp_q.pop_front());
      occ--;
      delivered++;
    end
    if (acc) begin
      exp_q.push_back(b ? d : ref_enc(d));
      orig_q.push_back(d);
      byp_q.push_back(b);
      occ++;
    end
    check("out_valid", 64'(out_valid), 64'(occ > 0));
    check("in_ready", 64'(in_ready), 64'(occ < 2));
    check("blk_cnt", 64'(blk_cnt), 64'(delivered));
    check("blk_cnt4", 64'(blk_cnt4), 64'(delivered % 16));
    check("out_valid4", 64'(out_valid4), 64'(occ > 0));
    if (occ > 0) begin
      check("data_front", data_out, exp_q[0]);
      check("data_front4", data_out4, exp_q[0]);
    end
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_cnt", 64'(blk_cnt), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] b0, b1, b2;
    int sent, cyc;
    bit v, r;
    logic [63:0] d;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);
    check("reset_data", data_out, 64'd0);
    check("reset_cnt", 64'(blk_cnt), 64'd0);
    rst = 1'b0;

    // Directed vectors
    cycle(1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b1);
    check("vec1", data_out, 64'h0006_0002_0006_0007);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("vec1_cnt", 64'(blk_cnt), 64'd1);
    cycle(1'b1, 64'hFFFF_0000_0000_0000, 1'b0, 1'b1);
    check("vec2", data_out, 64'hFFFF_0000_FFFF_FFFF);
    cycle(1'b1, 64'hFFFF_0000_0000_0000, 1'b1, 1'b1);
    check("vec2_bypass", data_out, 64'hFFFF_0000_0000_0000);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);

    // Back-pressure: three beats offered, two taken
    b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    cycle(1'b1, b0, 1'b0, 1'b0);
    cycle(1'b1, b1, 1'b0, 1'b0);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    cycle(1'b1, b2, 1'b0, 1'b0);
    check("bp_hold", data_out, ref_enc(b0));
    cycle(1'b1, b2, 1'b0, 1'b1);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    check("bp_second", data_out, ref_enc(b1));
    cycle(1'b1, b2, 1'b0, 1'b1);
    check("bp_third", data_out, ref_enc(b2));
    cycle(1'b0, 64'd0, 1'b0, 1'b1);

    // Streaming round-trip, 1000 random beats
    apply_reset();
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom};
      if (v && occ < 2) sent++;
      cycle(v, d, 1'b0, r);
      cyc++;
    end
    while (occ > 0 && cyc < 20000) begin
      cycle(1'b0, 64'd0, 1'b0, 1'b1);
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'd1000);
    check("stream_cnt", 64'(blk_cnt), 64'd1000);

    // Counter wrap on the 4-bit instance
    apply_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("wrap_cnt4", 64'(blk_cnt4), 64'd1);
    check("wrap_cnt32", 64'(blk_cnt), 64'd17);

    // Reset with main and skid both full
    cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    check("pre_rst_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_cnt", 64'(blk_cnt), 64'd0);
    check("mid_rst_data", data_out, 64'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b1);
    check("post_rst_data", data_out, 64'h0006_0002_0006_0007);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("post_rst_cnt", 64'(blk_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
